// File: rtl/uart_sender.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. TX_STATUS is high while idle; both outputs are registered.
module uart_sender #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          status_q, status_d;
  logic          bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign UART_TX   = tx_q;
  assign TX_STATUS = status_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (TX_EN) begin
          // Parity is resolved at acceptance so later TX_DATA changes cannot leak in.
          shift_d = TX_DATA;
          par_d   = (PARITY == 1) ? ~(^TX_DATA) : (^TX_DATA);
          baud_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) state_d = S_IDLE;
          else                             stop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the line changes on the bit edge itself.
  always_comb begin
    tx_d     = 1'b1;
    status_d = 1'b0;
    case (state_d)
      S_IDLE:   status_d = 1'b1;
      S_START:  tx_d     = 1'b0;
      S_DATA:   tx_d     = shift_d[bit_d];
      S_PARITY: tx_d     = par_d;
      default:  tx_d     = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: three parameterisations share one stimulus stream and
// are checked every cycle against a frame-level model plus literal expectations.
module tb_uart_sender;
  localparam int C = 4;
  localparam int P [3] = '{0, 2, 1};
  localparam int S [3] = '{1, 2, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [2:0] st_w, tx_w;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level model state per configuration
  bit          act [3];
  int          t   [3];
  logic [11:0] fb  [3];

  bit log_on = 1'b0;
  bit line_q [$];
  bit st_q   [$];

  always #5 clk = ~clk;

  uart_sender #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(st_w[0]), .UART_TX(tx_w[0]));
  uart_sender #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(st_w[1]), .UART_TX(tx_w[1]));
  uart_sender #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(st_w[2]), .UART_TX(tx_w[2]));

  function automatic logic [11:0] frame(input logic [7:0] d, input int p);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (p == 1)      f[9] = ~(^d);
    else if (p == 2) f[9] = ^d;
    return f;
  endfunction

  function automatic int flen(input int i);
    return (9 + ((P[i] != 0) ? 1 : 0) + S[i]) * C;
  endfunction

  task automatic chk(input string nm, input logic [11:0] a, input logic [11:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare every DUT mid-cycle.
  task automatic tick();
    logic [11:0] f;
    logic        e;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!reset) act[i] = 1'b0;
      else if (!act[i]) begin
        if (tx_en) begin
          act[i] = 1'b1;
          t[i]   = 0;
          fb[i]  = frame(tx_data, P[i]);
        end
      end else if (t[i] == flen(i) - 1) act[i] = 1'b0;
      else t[i] = t[i] + 1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      f = fb[i];
      e = act[i] ? f[t[i] / C] : 1'b1;
      chk($sformatf("line[%0d]", i), tx_w[i], e);
      chk($sformatf("status[%0d]", i), st_w[i], !act[i]);
    end
    if (log_on) begin
      line_q.push_back(tx_w[0]);
      st_q.push_back(st_w[0]);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (st_w !== 3'b111 && k < 300) begin
      tick();
      k++;
    end
    chk("idle_timeout", (k < 300), 1'b1);
    tick();
    tick();
  endtask

  // Send one byte; measure TX_STATUS low time, check dut0's bit pattern and the parity bits.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] pat,
                           input logic pp1, input logic pp2, input int busy_at);
    int n [3];
    int k;
    tx_data = d;
    tx_en   = 1'b1;
    tick();
    tx_en = 1'b0;
    n = '{0, 0, 0};
    k = 0;
    while (st_w !== 3'b111 && k < 300) begin
      for (int i = 0; i < 3; i++) if (!st_w[i]) n[i]++;
      if ((k % C) == 2 && (k / C) < 10) chk("pattern0", tx_w[0], pat[k / C]);
      if (k == 38) begin
        chk("parity_even", tx_w[1], pp1);
        chk("parity_odd", tx_w[2], pp2);
      end
      if (k == busy_at) begin
        tx_en   = 1'b1;
        tx_data = 8'hFF;
      end else if (k == busy_at + 1) tx_en = 1'b0;
      tick();
      k++;
    end
    chk("frame_timeout", (k < 300), 1'b1);
    chk("len0", n[0], 40);
    chk("len1", n[1], 48);
    chk("len2", n[2], 48);
    tick();
    tick();
  endtask

  initial begin
    logic [11:0] fv;
    logic [7:0]  rx [4];
    logic [7:0]  v;
    int          rx_n;
    int          i;

    // model pins
    fv = frame(8'h55, 0); chk("model_55", fv, 12'hEAA);
    fv = frame(8'h07, 2); chk("model_even07", fv[9], 1'b1);
    fv = frame(8'h07, 1); chk("model_odd07", fv[9], 1'b0);

    // reset held with TX_EN high
    reset = 1'b0; tx_en = 1'b1; tx_data = 8'h55;
    repeat (3) begin
      tick();
      chk("rst_line", tx_w, 3'b111);
      chk("rst_status", st_w, 3'b111);
    end
    reset = 1'b1; tx_en = 1'b0;
    repeat (3) tick();
    chk("post_rst_line", tx_w, 3'b111);

    run_frame(8'h55, 10'b10_1010_1010, 1'b0, 1'b1, -1);
    run_frame(8'hA3, 10'b11_0100_0110, 1'b0, 1'b1, 9);
    run_frame(8'h07, 10'b10_0000_1110, 1'b1, 1'b0, -1);

    // reset mid-frame
    tx_data = 8'h00; tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    repeat (14) tick();
    reset = 1'b0;
    tick();
    chk("midrst_line", tx_w, 3'b111);
    chk("midrst_status", st_w, 3'b111);
    reset = 1'b1;
    tick();
    run_frame(8'h00, 10'b10_0000_0000, 1'b0, 1'b1, -1);

    // back-to-back with TX_EN held high
    log_on = 1'b1; tx_data = 8'h31; tx_en = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      if (k == 0) tx_data = 8'h32;
      if (k == 41) tx_en = 1'b0;
      tick();
    end
    tx_en = 1'b0; log_on = 1'b0;
    wait_idle();

    chk("b2b_st39", st_q[39], 1'b0);
    chk("b2b_st40", st_q[40], 1'b1);
    chk("b2b_st41", st_q[41], 1'b0);
    chk("b2b_start41", line_q[41], 1'b0);

    rx_n = 0;
    i = 0;
    while (i < line_q.size()) begin
      if (line_q[i] == 1'b0 && i + 10 * C <= line_q.size()) begin
        for (int b = 0; b < 8; b++) v[b] = line_q[i + C * (b + 1) + C / 2];
        if (rx_n < 4) rx[rx_n] = v;
        rx_n++;
        i = i + 10 * C;
      end else i++;
    end
    chk("rx_count", rx_n, 2);
    if (rx_n >= 2) begin
      chk("rx_byte0", rx[0], 8'h31);
      chk("rx_byte1", rx[1], 8'h32);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
